// File: rtl/data_mem_stack.sv
// Single-port data memory with a hardware stack in the top STACK_DEPTH words.
// Optional post-reset memory clear FSM is enabled by defining DMEM_CLEAR_EN.
module data_mem_stack #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] read_data,
  output logic [ADDR_W:0]   sp,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              busy
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned SP_W     = ADDR_W + 1;
  localparam logic [1:0]  OP_STORE = 2'b01;
  localparam logic [1:0]  OP_PUSH  = 2'b10;
  localparam logic [1:0]  OP_POP   = 2'b11;
  localparam logic [ADDR_W:0] SP_EMPTY = SP_W'(DEPTH);
  localparam logic [ADDR_W:0] SP_FULL  = SP_W'(DEPTH - STACK_DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [ADDR_W:0]   sp_dec, sp_inc;
  logic [ADDR_W-1:0] read_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  // Clear FSM state register; reset always restarts the sweep at address 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    busy     = (state_q == ST_CLEAR);
    clr_we   = (state_q == ST_CLEAR);
    clr_addr = clr_addr_q;
  end
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign empty     = (sp_q == SP_EMPTY);
  assign full      = (sp_q == SP_FULL);
  assign sp        = sp_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign sp_dec    = sp_q - SP_W'(1);
  assign sp_inc    = sp_q + SP_W'(1);

  // Zero-latency read: POP reads the current top of stack
  always_comb begin
    read_addr = (op == OP_POP) ? sp_q[ADDR_W-1:0] : addr;
    if (busy || (op == OP_POP && empty)) begin
      read_data = '0;
    end else begin
      read_data = mem_q[read_addr];
    end
  end

  // Single write port shared by clear sweep, STORE and PUSH
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = write_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (!busy) begin
      if (op == OP_STORE) begin
        mem_we = 1'b1;
      end else if (op == OP_PUSH && !full) begin
        mem_we    = 1'b1;
        mem_waddr = sp_dec[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Stack pointer and sticky flags; a new error beats clr_err in the same cycle
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (!busy) begin
      if (clr_err) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (op == OP_PUSH) begin
        if (full) ovf_d = 1'b1;
        else      sp_d  = sp_dec;
      end else if (op == OP_POP) begin
        if (empty) udf_d = 1'b1;
        else       sp_d  = sp_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= SP_EMPTY;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

endmodule

// File: tb/tb_data_mem_stack.sv
// Bench for data_mem_stack: directed scenarios then random ops against a word-level model.
module tb_data_mem_stack;

  localparam int DEPTH = 256;
  localparam int SD    = 32;
  localparam logic [1:0] NOP = 2'b00, STORE = 2'b01, PUSH = 2'b10, POP = 2'b11;
`ifdef DMEM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [7:0] addr;
  logic [7:0] write_data;
  logic       clr_err;
  logic [7:0] read_data;
  logic [8:0] sp;
  logic       empty, full, overflow, underflow, busy;

  data_mem_stack dut (
    .clk(clk), .reset(reset), .op(op), .addr(addr), .write_data(write_data),
    .clr_err(clr_err), .read_data(read_data), .sp(sp), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] m_mem [DEPTH];
  bit         m_val [DEPTH];
  int         m_sp;
  bit         m_ovf, m_udf;
  int         n_pass = 0;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sp"},    32'(sp),        32'(m_sp));
    check({tag, "_empty"}, 32'(empty),     32'(m_sp == DEPTH));
    check({tag, "_full"},  32'(full),      32'(m_sp == DEPTH - SD));
    check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, "_udf"},   32'(underflow), 32'(m_udf));
    check({tag, "_busy"},  32'(busy),      32'(0));
  endtask

  // One op per cycle: check combinational read before the edge, state after it
  task automatic step(input string tag, input logic [1:0] o, input logic [7:0] a,
                      input logic [7:0] d, input logic c);
    logic [7:0] exp_rd;
    bit         known;
    op = o; addr = a; write_data = d; clr_err = c;
    #2;
    known  = 1'b0;
    exp_rd = 8'h00;
    if (o == POP) begin
      if (m_sp == DEPTH) known = 1'b1;
      else if (m_val[m_sp]) begin known = 1'b1; exp_rd = m_mem[m_sp]; end
    end else if (m_val[a]) begin
      known = 1'b1; exp_rd = m_mem[a];
    end
    if (known) check({tag, "_rd"}, 32'(read_data), 32'(exp_rd));
    @(posedge clk);
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    case (o)
      STORE: begin m_mem[a] = d; m_val[a] = 1'b1; end
      PUSH: begin
        if (m_sp == DEPTH - SD) m_ovf = 1'b1;
        else begin m_sp--; m_mem[m_sp] = d; m_val[m_sp] = 1'b1; end
      end
      POP: begin
        if (m_sp == DEPTH) m_udf = 1'b1;
        else m_sp++;
      end
      default: ;
    endcase
    #1;
    check_state(tag);
    op = NOP; clr_err = 1'b0;
  endtask

  // Waits out the clear sweep, bounded, and checks its length
  task automatic wait_clear(input string tag);
    int cnt = 0;
    op = STORE; addr = 8'h10; write_data = 8'hFF;
    while (busy && cnt < 400) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(DEPTH));
    op = NOP;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 8'h00; m_val[i] = 1'b1; end
  endtask

  initial begin
    logic [1:0] ro;
    logic [7:0] ra;
    int         sel;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    m_sp = DEPTH; m_ovf = 1'b0; m_udf = 1'b0;
    op = NOP; addr = '0; write_data = '0; clr_err = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sp", 32'(sp), 32'(DEPTH));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_flags", 32'({overflow, underflow}), 32'(0));
    check("rst_busy", 32'(busy), 32'(CLR_EN));
    @(negedge clk) reset = 1'b0;

    if (CLR_EN) begin
      repeat (100) @(posedge clk);
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      wait_clear("clr");
      step("clr_ignored", NOP, 8'h10, 8'h00, 1'b0);
      step("clr_zero", NOP, 8'h9C, 8'h00, 1'b0);
    end

    // Store then load
    step("t1_st", STORE, 8'h10, 8'hA5, 1'b0);
    step("t1_ld", NOP,   8'h10, 8'h00, 1'b0);
    check("t1_value", 32'(read_data), 32'h0000_00A5);

    // Push three, load top, pop three
    step("t2_p1", PUSH, 8'h00, 8'h11, 1'b0);
    step("t2_p2", PUSH, 8'h00, 8'h22, 1'b0);
    step("t2_p3", PUSH, 8'h00, 8'h33, 1'b0);
    check("t2_sp253", 32'(sp), 32'd253);
    step("t2_ld253", NOP, 8'd253, 8'h00, 1'b0);
    check("t2_mem253", 32'(read_data), 32'h33);
    step("t2_q1", POP, 8'h00, 8'h00, 1'b0);
    step("t2_q2", POP, 8'h00, 8'h00, 1'b0);
    step("t2_q3", POP, 8'h00, 8'h00, 1'b0);
    check("t2_empty", 32'({sp, empty, underflow}), 32'({9'd256, 1'b1, 1'b0}));

    // Fill, overflow, clear
    step("t3_guard", STORE, 8'd223, 8'h5C, 1'b0);
    for (int i = 0; i < SD; i++) step("t3_push", PUSH, 8'h00, 8'(8'h40 + i), 1'b0);
    check("t3_full", 32'({full, sp}), 32'({1'b1, 9'd224}));
    step("t3_ovf", PUSH, 8'h00, 8'h77, 1'b0);
    check("t3_ovf_flag", 32'({overflow, sp}), 32'({1'b1, 9'd224}));
    step("t3_ld223", NOP, 8'd223, 8'h00, 1'b0);
    step("t3_clr", NOP, 8'h00, 8'h00, 1'b1);
    check("t3_ovf_clr", 32'(overflow), 32'(0));
    for (int i = 0; i < SD; i++) step("t3_pop", POP, 8'h00, 8'h00, 1'b0);

    // Underflow; clr_err loses to a same-cycle error
    step("t4_udf", POP, 8'h00, 8'h00, 1'b0);
    check("t4_udf_flag", 32'({underflow, sp}), 32'({1'b1, 9'd256}));
    step("t4_clr_vs_err", POP, 8'h00, 8'h00, 1'b1);
    check("t4_udf_sticky", 32'(underflow), 32'(1));

    // Async reset mid-cycle
    for (int i = 0; i < 5; i++) step("t6_push", PUSH, 8'h00, 8'(8'hC0 + i), 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_async_sp", 32'(sp), 32'(DEPTH));
    check("t6_async_flags", 32'({overflow, underflow, empty}), 32'(3'b001));
    m_sp = DEPTH; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk) reset = 1'b0;
    if (CLR_EN) wait_clear("t6");

    // Random mix biased toward the stack region and a few low addresses
    repeat (600) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      ro = NOP;
      else if (sel < 5) ro = STORE;
      else if (sel < 8) ro = PUSH;
      else              ro = POP;
      ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(220, 255)) : 8'($urandom_range(0, 15));
      step("rnd", ro, ra, 8'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
